// File: rtl/fetch_buffer.sv
// Instruction-fetch unit: keeps one memory read in flight and buffers up to DEPTH
// fetched {pc, ins} pairs. Optional JAL target prediction via FETCH_JAL_PREDICT_EN.
module fetch_buffer #(
  parameter int              PC_W     = 32,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ready_i,
  output logic             mem_req_o,
  output logic [PC_W-1:0]  mem_addr_o,
  input  logic             mem_ok_i,
  input  logic [INS_W-1:0] mem_din_i,
  input  logic             insq_full_i,
  output logic             flag_o,
  output logic [INS_W-1:0] cur_ins_o,
  output logic [PC_W-1:0]  cur_pc_o,
  input  logic             jump_i,
  input  logic [PC_W-1:0]  pc_jump_to_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

  state_e           state_q;
  logic [PC_W-1:0]  fetch_pc_q;
  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [INS_W-1:0] ins_mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             mem_req_q, flag_q;
  logic [PC_W-1:0]  mem_addr_q, cur_pc_q;
  logic [INS_W-1:0] cur_ins_q;

  logic             pop, push, credit;
  logic [CW-1:0]    count_d;
  logic [PC_W-1:0]  push_pc_d;

  assign pop     = (count_q != '0) && !insq_full_i;
  assign push    = (state_q == S_WAIT) && mem_ok_i;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // Credit counts the read about to be issued as an occupied slot.
  assign credit  = count_d < CW'(DEPTH);

`ifdef FETCH_JAL_PREDICT_EN
  logic [20:0] jal_imm;
  assign jal_imm   = {mem_din_i[31], mem_din_i[19:12], mem_din_i[20], mem_din_i[30:21], 1'b0};
  assign push_pc_d = (mem_din_i[6:0] == 7'b1101111)
                   ? mem_addr_q + {{(PC_W-21){jal_imm[20]}}, jal_imm}
                   : mem_addr_q + PC_W'(4);
`else
  assign push_pc_d = mem_addr_q + PC_W'(4);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      flag_q     <= 1'b0;
      cur_ins_q  <= '0;
      cur_pc_q   <= '0;
    end else if (ready_i) begin
      mem_req_q <= 1'b0;
      flag_q    <= 1'b0;
      if (jump_i) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        fetch_pc_q <= pc_jump_to_i & ~PC_W'(3);
        // A read still in flight must be drained before the target is requested.
        state_q    <= (state_q != S_IDLE && !mem_ok_i) ? S_DRAIN : S_IDLE;
      end else begin
        if (pop) begin
          cur_ins_q <= ins_mem_q[rd_ptr_q];
          cur_pc_q  <= pc_mem_q[rd_ptr_q];
          flag_q    <= 1'b1;
          rd_ptr_q  <= rd_ptr_q + AW'(1);
        end
        if (push) begin
          pc_mem_q[wr_ptr_q]  <= mem_addr_q;
          ins_mem_q[wr_ptr_q] <= mem_din_i;
          wr_ptr_q            <= wr_ptr_q + AW'(1);
        end
        count_q <= count_d;
        case (state_q)
          S_IDLE: begin
            if (credit) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_pc_q;
              state_q    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_ok_i) begin
              fetch_pc_q <= push_pc_d;
              if (credit) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= push_pc_d;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_DRAIN: begin
            if (mem_ok_i) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_pc_q;
              state_q    <= S_WAIT;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign flag_o     = flag_q;
  assign cur_ins_o  = cur_ins_q;
  assign cur_pc_o   = cur_pc_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: transaction-level model plus a latency-programmable
// memory responder, directed scenarios followed by a randomized stream.
module tb_fetch_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i, ready_i, mem_req_o, mem_ok_i, insq_full_i, flag_o, jump_i;
  logic [31:0] mem_addr_o, mem_din_i, cur_ins_o, cur_pc_o, pc_jump_to_i;

  always #5 clk = ~clk;

  fetch_buffer #(.PC_W(32), .INS_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .reset_i(reset_i), .ready_i(ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ok_i(mem_ok_i), .mem_din_i(mem_din_i),
    .insq_full_i(insq_full_i), .flag_o(flag_o),
    .cur_ins_o(cur_ins_o), .cur_pc_o(cur_pc_o),
    .jump_i(jump_i), .pc_jump_to_i(pc_jump_to_i)
  );

  int tests = 0, fails = 0, cyc = 0;

  // memory responder
  bit          mp;
  int          mcnt, lat;
  bit          jal_mode;
  logic [31:0] maddr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    logic [31:0] h;
    if (jal_mode && a == 32'h8) return 32'h0100006F;
    h = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {h[31:7], 7'h13};
  endfunction

  // behavioural model: FIFO as a queue, one outstanding-read flag, one stale flag
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  bit          m_out, m_stale;
  logic [31:0] m_fpc;
  logic        e_req, e_flag;
  logic [31:0] e_addr, e_ins, e_pc;

  function automatic logic [31:0] npc(input logic [31:0] a, input logic [31:0] ins);
    logic [20:0] im;
    im = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef FETCH_JAL_PREDICT_EN
    if (ins[6:0] == 7'b1101111) return a + {{11{im[20]}}, im};
`endif
    return a + 32'd4;
  endfunction

  task automatic model_edge(input bit rst, input bit rdy, input bit ok, input logic [31:0] din,
                            input bit full, input bit jmp, input logic [31:0] tgt);
    if (rst) begin
      mq.delete(); m_out = 0; m_stale = 0; m_fpc = 32'h0;
      e_req = 0; e_flag = 0; e_addr = 0; e_ins = 0; e_pc = 0;
      return;
    end
    if (!rdy) return;
    e_req = 0; e_flag = 0;
    if (jmp) begin
      mq.delete();
      m_fpc = tgt & ~32'd3;
      if (m_out && !ok) m_stale = 1;
      else begin m_out = 0; m_stale = 0; end
    end else begin
      if (mq.size() > 0 && !full) begin
        e_flag = 1; e_pc = mq[0].pc; e_ins = mq[0].ins;
        void'(mq.pop_front());
      end
      if (m_out && ok) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin
          mq.push_back({e_addr, din});
          m_fpc = npc(e_addr, din);
        end
      end
      if (!m_out && mq.size() < DEPTH) begin
        e_req = 1; e_addr = m_fpc; m_out = 1;
      end
    end
  endtask

  logic [31:0] req_log[$], dlv_log[$];
  int          dlv_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    tests++; fails++;
    $display("FAIL %s: event not seen within bound", nm);
  endtask

  task automatic chk_q(input string nm, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
    if (idx < q.size()) chk(nm, q[idx], exp);
    else miss(nm);
  endtask

  task automatic step(input bit rdy, input bit full, input bit jmp, input logic [31:0] tgt, input bit rst);
    logic        req_pre;
    logic [31:0] addr_pre;
    reset_i = rst; ready_i = rdy; insq_full_i = full; jump_i = jmp; pc_jump_to_i = tgt;
    mem_ok_i  = !rst && rdy && mp && (mcnt == 0);
    mem_din_i = mem_ok_i ? mdata(maddr) : $urandom;
    req_pre = mem_req_o; addr_pre = mem_addr_o;
    @(posedge clk);
    model_edge(rst, rdy, mem_ok_i, mem_din_i, full, jmp, tgt);
    if (rst) mp = 0;
    else if (rdy) begin
      if (mem_ok_i) mp = 0;
      else if (mp && mcnt > 0) mcnt--;
      if (req_pre) begin
        mp = 1; maddr = addr_pre;
        mcnt = (lat == 0) ? int'($urandom_range(0, 3)) : lat - 1;
      end
    end
    #1;
    cyc++;
    chk("mem_req", {31'b0, mem_req_o}, {31'b0, e_req});
    chk("mem_addr", mem_addr_o, e_addr);
    chk("flag", {31'b0, flag_o}, {31'b0, e_flag});
    chk("cur_ins", cur_ins_o, e_ins);
    chk("cur_pc", cur_pc_o, e_pc);
    if (!rst && rdy && mem_req_o) req_log.push_back(mem_addr_o);
    if (!rst && rdy && flag_o) begin dlv_log.push_back(cur_pc_o); dlv_cyc.push_back(cyc); end
  endtask

  task automatic do_reset();
    repeat (2) step(1, 0, 0, 0, 1);
    req_log.delete(); dlv_log.delete(); dlv_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    reset_i = 1; ready_i = 1; insq_full_i = 0; jump_i = 0; pc_jump_to_i = 0;
    mem_ok_i = 0; mem_din_i = 0; mp = 0; mcnt = 0; maddr = 0; lat = 1; jal_mode = 0;
    model_edge(1, 1, 0, 0, 0, 0, 0);

    // sequential fetch, latency 1
    do_reset();
    repeat (12) step(1, 0, 0, 0, 0);
    chk_q("s1_req0", req_log, 0, 32'h0);
    chk_q("s1_req1", req_log, 1, 32'h4);
    chk_q("s1_req2", req_log, 2, 32'h8);
    chk_q("s1_dlv0", dlv_log, 0, 32'h0);
    chk_q("s1_dlv1", dlv_log, 1, 32'h4);
    chk_q("s1_dlv2", dlv_log, 2, 32'h8);

    // backpressure: exactly DEPTH reads, then release
    do_reset();
    repeat (20) step(1, 1, 0, 0, 0);
    chk("s2_nreq", req_log.size(), 32'd4);
    chk("s2_ndlv", dlv_log.size(), 32'd0);
    req_log.delete();
    repeat (6) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk_q("s2_dlv", dlv_log, i, 32'(4 * i));
    if (dlv_cyc.size() >= 4) chk("s2_consec", 32'(dlv_cyc[3] - dlv_cyc[0]), 32'd3);
    else miss("s2_consec");
    chk_q("s2_resume", req_log, 0, 32'h10);

    // jump while read of 0x20 is outstanding, latency 3
    do_reset();
    lat = 3; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1, 0, 0, 0, 0);
      if (mem_req_o && mem_addr_o == 32'h20) found = 1;
    end
    if (!found) miss("s3_wait");
    step(1, 0, 1, 32'h103, 0);
    chk("s3_flag", {31'b0, flag_o}, 32'd0);
    req_log.delete(); dlv_log.delete();
    repeat (20) step(1, 0, 0, 0, 0);
    chk_q("s3_req", req_log, 0, 32'h100);
    chk_q("s3_dlv0", dlv_log, 0, 32'h100);
    chk_q("s3_dlv1", dlv_log, 1, 32'h104);

    // jump coincident with mem_ok
    do_reset();
    lat = 2; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mp && mcnt == 0 && maddr >= 32'h10) found = 1;
      else step(1, 0, 0, 0, 0);
    end
    if (!found) miss("s4_wait");
    step(1, 0, 1, 32'h200, 0);
    chk("s4_flag", {31'b0, flag_o}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("s4_req", {31'b0, mem_req_o}, 32'd1);
    chk("s4_addr", mem_addr_o, 32'h200);

    // ready low for 5 cycles mid-stream
    do_reset();
    lat = 2;
    repeat (10) step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    repeat (25) step(1, 0, 0, 0, 0);
    if (dlv_log.size() < 6) miss("s5_count");
    foreach (dlv_log[i]) chk("s5_seq", dlv_log[i], 32'(4 * i));

    // JAL at pc 0x8
    do_reset();
    lat = 1; jal_mode = 1;
    for (int i = 0; i < 40 && req_log.size() < 4; i++) step(1, 0, 0, 0, 0);
`ifdef FETCH_JAL_PREDICT_EN
    chk_q("s6_jal", req_log, 3, 32'h18);
`else
    chk_q("s6_jal", req_log, 3, 32'hC);
`endif
    jal_mode = 0;

    // randomized stream
    do_reset();
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom & 32'h0000_FFFF);
      step(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 25) == 0, tgt, ($urandom % 500) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction-fetch unit with an internal prefetch FIFO. It sits between the memory controller and the instruction queue. It keeps one memory read outstanding and buffers up to `DEPTH` fetched instructions, so fetch runs ahead while the instruction queue is full. It flushes and refetches on a redirect from the commit stage.

## Interface
Parameters:
- `PC_W`, 32, program counter width.
- `INS_W`, 32, instruction width.
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 0, fetch address after reset.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ready` in 1: global enable; when low, all state and outputs hold.
- `mem_req` out 1: one-cycle pulse that issues a read of `mem_addr`.
- `mem_addr` out `PC_W`: read address; stable from the `mem_req` pulse until the matching `mem_ok`.
- `mem_ok` in 1: one-cycle pulse meaning `mem_din` holds the data for the outstanding read.
- `mem_din` in `INS_W`: returned instruction.
- `insq_full` in 1: instruction queue cannot accept this cycle.
- `flag` out 1: `cur_ins`/`cur_pc` are valid this cycle (one-cycle pulse per instruction).
- `cur_ins` out `INS_W`: delivered instruction.
- `cur_pc` out `PC_W`: PC of `cur_ins`.
- `jump` in 1: redirect request.
- `pc_jump_to` in `PC_W`: redirect target; bits [1:0] are forced to 0 internally.

## Operation
- **State:** `fetch_pc`, FIFO of {pc, ins} with `count`, and a request FSM with states IDLE, WAIT and DRAIN.
- **IDLE:** if `count + 1 ≤ DEPTH`:
  - pulse `mem_req` with `mem_addr = fetch_pc`;
  - go to WAIT.
- **WAIT:** on `mem_ok`:
  - push {`mem_addr`, `mem_din`};
  - set `fetch_pc = mem_addr + 4`, wrapping mod 2^`PC_W`;
  - if credit remains after the push, issue the next request on the same edge and stay in WAIT; otherwise go to IDLE.
- **DRAIN:** on `mem_ok`:
  - discard the data;
  - issue a request at `fetch_pc` on the same edge;
  - go to WAIT.
- **Delivery:** each cycle where FIFO is non-empty and `insq_full == 0`, register the head onto `cur_ins`/`cur_pc`, set `flag = 1` and pop. Otherwise `flag = 0`; `cur_ins`/`cur_pc` hold.
- **Push and pop on the same edge:** `count` is unchanged. Credit for issuing uses the post-push, post-pop count.
- **`jump`** has priority over everything in the same cycle:
  - flush the FIFO (`count = 0`);
  - set `flag = 0`;
  - set `fetch_pc = pc_jump_to & ~3`;
  - the FSM goes to DRAIN if in WAIT with no `mem_ok` this cycle, otherwise to IDLE.
  - A `mem_ok` in the jump cycle completes the outstanding read, and its data is discarded.
  - A `jump` while already in DRAIN only updates `fetch_pc`.
- **`ready == 0`:** nothing advances. `mem_ok` must not be presented while `ready` is low.
- **Reset:**
  - `fetch_pc = RESET_PC`, `count = 0`, FSM in IDLE;
  - `mem_req = 0`, `mem_addr = 0`, `flag = 0`, `cur_ins = 0`, `cur_pc = 0`.
  - Reset mid-request abandons the read. The memory controller is reset by the same signal.

## Timing
- First `mem_req` is pulsed at the first edge with `reset = 0` and `ready = 1`.
- Memory latency is ≥1 cycle from `mem_req` to `mem_ok`.
- Load-to-delivery: FIFO write on edge N; `flag` becomes high after edge N+1 at the earliest (no bypass).
- Sustained throughput is one instruction per memory round trip. The next request leaves on the same edge the response is accepted.
- Jump-to-new-request:
  - one edge from IDLE;
  - from DRAIN, the edge of the stale `mem_ok`.
- After a `jump`, the first delivery is the target instruction. No pre-jump instruction appears on `flag` after the jump edge.
- At most one read is ever outstanding. Instructions are never duplicated, dropped or reordered between jumps.

## Configuration
- **`FETCH_JAL_PREDICT_EN` defined:** on a WAIT-state push, if `mem_din[6:0] == 7'b1101111` (JAL), then `fetch_pc = mem_addr + sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})` instead of +4.
  - The delivered entry is unchanged; commit still validates it.
  - A later `jump` overrides the prediction as usual.
- **`FETCH_JAL_PREDICT_EN` not defined:** always `fetch_pc = mem_addr + 4`; no decode logic is present.

## Test plan
- **Reset and sequential fetch:** `RESET_PC = 0`, memory latency 1, `insq_full = 0`.
  - Requests go to 0x0, 0x4, 0x8.
  - `flag` pulses deliver pc 0x0, 0x4, 0x8 in order with matching `mem_din`.
- **Backpressure:** hold `insq_full = 1` for 20 cycles, `DEPTH = 4`.
  - Exactly 4 reads complete, then `mem_req` stays 0.
  - On release, the 4 buffered instructions are delivered on 4 consecutive cycles, then fetch resumes at 0x10.
- **Jump during WAIT:** `jump` with `pc_jump_to = 0x103` while a read of 0x20 is outstanding, latency 3.
  - The stale `mem_ok` data is discarded.
  - Next `mem_req` has `mem_addr = 0x100`; the first delivered `cur_pc` is 0x100.
- **Jump coincident with `mem_ok`:** the data is discarded, FIFO flushed, `flag = 0`; `mem_req` to the target on the next edge.
- **`ready` low for 5 cycles** mid-stream: outputs and state frozen; the sequence resumes with no gap or duplicate.
- **`FETCH_JAL_PREDICT_EN`:** instruction 0x0100006F (jal x0, +16) at pc 0x8; the next `mem_req` is 0x18. With the macro undefined, it is 0xC.
